matrix_packer: RTL

- Front end for the matrix multiplier: accepts a serial stream of signed matrix elements and assembles two packed square matrices, A then B.
- Presents the pair as packed words on a valid/ready output.
- Packed layout equals the multiplier's input layout: {m00, m01, ..., m(S-1)(S-1)}, row-major, element [0][0] in the MSBs.
- Detects malformed frames and resynchronises on the s_last marker.

---
 rtl/matrix_packer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/matrix_packer.sv
// Assembles a serial stream of signed elements into packed square matrices A and B,
// presented on a valid/ready pair. Define MATRIX_PACKER_TRANSPOSE_B_EN to pack B column-major.
module matrix_packer #(
    parameter int SIZE   = 2,
    parameter int ELEM_W = 8,
    localparam int PW    = SIZE * SIZE * ELEM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ELEM_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PW-1:0]     m_A,
    output logic [PW-1:0]     m_B,
    output logic              frame_err
);

    localparam int N     = SIZE * SIZE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD, DRAIN} state_t;

    state_t            state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [PW-1:0]     a_buf_reg, b_buf_reg;
    logic [PW-1:0]     a_next, b_next;
    logic [PW-1:0]     m_a_reg, m_b_reg;
    logic              s_ready_reg, m_valid_reg, frame_err_reg;
    logic              xfer;
    logic [IDX_W-1:0]  b_slot [N];

    assign xfer      = s_valid && s_ready_reg;
    assign s_ready   = s_ready_reg;
    assign m_valid   = m_valid_reg;
    assign m_A       = m_a_reg;
    assign m_B       = m_b_reg;
    assign frame_err = frame_err_reg;

    // Destination slot of each incoming B element.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bmap
`ifdef MATRIX_PACKER_TRANSPOSE_B_EN
            assign b_slot[gi] = IDX_W'((gi % SIZE) * SIZE + gi / SIZE);
`else
            assign b_slot[gi] = IDX_W'(gi);
`endif
        end
    endgenerate

    // Shadow buffers with the current element merged in; committed only on a valid transfer.
    always_comb begin
        a_next = a_buf_reg;
        b_next = b_buf_reg;
        a_next[PW - 1 - int'(idx_reg) * ELEM_W -: ELEM_W]         = s_data;
        b_next[PW - 1 - int'(b_slot[idx_reg]) * ELEM_W -: ELEM_W] = s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= LOAD_A;
            idx_reg       <= '0;
            s_ready_reg   <= 1'b0;
            m_valid_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            m_a_reg       <= '0;
            m_b_reg       <= '0;
            a_buf_reg     <= '0;
            b_buf_reg     <= '0;
        end else begin
            frame_err_reg <= 1'b0;
            case (state_reg)
                LOAD_A: begin
                    s_ready_reg <= 1'b1;
                    if (xfer) begin
                        if (s_last) begin
                            frame_err_reg <= 1'b1;
                            idx_reg       <= '0;
                        end else begin
                            a_buf_reg <= a_next;
                            if (idx_reg == LAST_IDX) begin
                                idx_reg   <= '0;
                                state_reg <= LOAD_B;
                            end else begin
                                idx_reg <= idx_reg + 1'b1;
                            end
                        end
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
                        if (s_last && idx_reg != LAST_IDX) begin
                            frame_err_reg <= 1'b1;
                            idx_reg       <= '0;
                            state_reg     <= LOAD_A;
                        end else if (idx_reg == LAST_IDX && s_last) begin
                            // Publish the complete pair; B's last element comes straight from b_next.
                            m_a_reg     <= a_buf_reg;
                            m_b_reg     <= b_next;
                            m_valid_reg <= 1'b1;
                            s_ready_reg <= 1'b0;
                            idx_reg     <= '0;
                            state_reg   <= HOLD;
                        end else if (idx_reg == LAST_IDX) begin
                            frame_err_reg <= 1'b1;
                            idx_reg       <= '0;
                            state_reg     <= DRAIN;
                        end else begin
                            b_buf_reg <= b_next;
                            idx_reg   <= idx_reg + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid_reg <= 1'b0;
                        s_ready_reg <= 1'b1;
                        idx_reg     <= '0;
                        state_reg   <= LOAD_A;
                    end
                end
                DRAIN: begin
                    if (xfer && s_last) begin
                        idx_reg   <= '0;
                        state_reg <= LOAD_A;
                    end
                end
                default: state_reg <= LOAD_A;
            endcase
        end
    end

endmodule
